data_memory_unit: RTL and testbench

Parametrised data-memory stage for the RISC pipeline, the successor to the fixed 16-bit single-cycle memory stage. It provides a byte-addressed, big-endian data RAM with configurable word width, depth and wait states, plus byte or full-word access, sign- or zero-extended byte loads and out-of-range fault detection. It sits between execute and write-back, stalls the pipeline during multi-cycle accesses, and still resolves the branch select (PCSrc).

---
 rtl/mem_pkg.sv | 25 ++
 rtl/byte_lane_ram.sv | 56 +++++
 rtl/data_memory_unit.sv | 149 ++++++++++++++
 tb/tb_data_memory_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory stage.
//   - mem_state_t : access sequencer states (IDLE, WAIT)
//   - num_bytes   : bytes per word for a given word width
//   - extend_byte : sign/zero extension of a loaded byte to the widest
//                   supported word; callers keep the low DATA_W bits.
package mem_pkg;

  // Widest word the extension helper can produce.
  localparam int MAX_DATA_W = 256;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  function automatic int num_bytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] extend_byte(input logic [7:0] b,
                                                        input logic       sign_ext);
    return sign_ext ? {{(MAX_DATA_W-8){b[7]}}, b} : {{(MAX_DATA_W-8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: byte-addressed big-endian RAM, synchronous write,
// combinational read of NB consecutive bytes starting at i_addr.
// Ports:
//   clk      : clock
//   i_addr   : byte address (most significant byte of a word)
//   i_we     : write enable (caller guarantees the access is in range)
//   i_byte   : 1 = write only byte i_addr with i_wdata[7:0], 0 = whole word
//   i_wdata  : write word
//   o_rdata  : bytes i_addr .. i_addr+NB-1, first byte in the MSBs;
//              lanes falling past the end of the array read as zero
module byte_lane_ram
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic              i_byte,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int NB    = num_bytes(DATA_W);
  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

  logic [7:0] r_mem [DEPTH_BYTES];

  // Per-lane address, computed one bit wider so the last lane never wraps.
  logic [ADDR_W:0] w_lane_addr  [NB];
  logic            w_lane_in    [NB];
  logic [7:0]      w_lane_wdata [NB];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign w_lane_addr[gi]  = {1'b0, i_addr} + (ADDR_W+1)'(gi);
      assign w_lane_in[gi]    = (w_lane_addr[gi] < DEPTH_L);
      assign w_lane_wdata[gi] = i_byte ? i_wdata[7:0] : i_wdata[DATA_W-1-8*gi -: 8];
      assign o_rdata[DATA_W-1-8*gi -: 8] =
        w_lane_in[gi] ? r_mem[w_lane_addr[gi][IDX_W-1:0]] : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      // A byte write touches lane 0 only.
      if (i_we && w_lane_in[i] && (!i_byte || i == 0)) begin
        r_mem[w_lane_addr[i][IDX_W-1:0]] <= w_lane_wdata[i];
      end
    end
  end

endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: pipeline data-memory stage with configurable word
// width, depth and wait states. Big-endian byte RAM, byte or word access,
// sign/zero-extended byte loads, out-of-range fault detection.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   address                 : byte address (MSB byte for word accesses)
//   write_data              : store data
//   MemRead / MemWrite      : load / store request (both = read-before-write)
//   ByteAccess / SignedLoad : access size, byte-load extension mode
//   Branch / Zero           : branch resolution inputs
//   read_data_mem           : registered load result (0 after a fault)
//   PCSrc_out               : Branch & Zero, combinational
//   mem_stall               : hold inputs stable while high
//   mem_fault               : one-cycle pulse after an out-of-range access
module data_memory_unit
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              ByteAccess,
  input  logic              SignedLoad,
  input  logic              Branch,
  input  logic              Zero,
  output logic [DATA_W-1:0] read_data_mem,
  output logic              PCSrc_out,
  output logic              mem_stall,
  output logic              mem_fault
);

  localparam int NB       = num_bytes(DATA_W);
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam int CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = HAS_WAIT ? CNT_W'(WAIT_STATES-1) : '0;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0]   SPAN_L   = (ADDR_W+1)'(NB-1);

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op_read;
  logic             r_op_write;
  logic [DATA_W-1:0] r_read_data;
  logic             r_fault;

  logic              w_req;
  logic              w_complete;
  logic              w_do_read;
  logic              w_do_write;
  logic [ADDR_W:0]   w_last_addr;
  logic              w_fault;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_rdata;
  logic [MAX_DATA_W-1:0] w_ext_full;
  logic [DATA_W-1:0] w_load_value;
  logic              w_unused_ext;

  assign w_req = MemRead | MemWrite;

  // Completion: immediately from IDLE when there are no wait states,
  // otherwise on the WAIT cycle whose countdown has reached zero.
  assign w_complete = ((r_state == ST_IDLE) && w_req && !HAS_WAIT) ||
                      ((r_state == ST_WAIT) && (r_cnt == '0));

  // The operation kind is captured when the access starts, so a request
  // line dropped during WAIT does not cancel it; address and data are
  // taken from the (stable) inputs at completion.
  assign w_do_read  = (r_state == ST_IDLE) ? MemRead  : r_op_read;
  assign w_do_write = (r_state == ST_IDLE) ? MemWrite : r_op_write;

  // Last byte touched, one bit wider than the address: no wrap-around.
  assign w_last_addr = {1'b0, address} + (ByteAccess ? '0 : SPAN_L);
  assign w_fault     = (w_last_addr >= DEPTH_L);

  assign w_ram_we = w_complete && w_do_write && !w_fault && !rst;

  byte_lane_ram #(
    .DATA_W      (DATA_W),
    .DEPTH_BYTES (DEPTH_BYTES),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_addr  (address),
    .i_we    (w_ram_we),
    .i_byte  (ByteAccess),
    .i_wdata (write_data),
    .o_rdata (w_rdata)
  );

  // The addressed byte is the most significant lane of the read word.
  assign w_ext_full   = extend_byte(w_rdata[DATA_W-1 -: 8], SignedLoad);
  assign w_load_value = ByteAccess ? w_ext_full[DATA_W-1:0] : w_rdata;
  assign w_unused_ext = ^w_ext_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op_read   <= 1'b0;
      r_op_write  <= 1'b0;
      r_read_data <= '0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && HAS_WAIT) begin
            r_state    <= ST_WAIT;
            r_cnt      <= CNT_LOAD;
            r_op_read  <= MemRead;
            r_op_write <= MemWrite;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Read data is sampled before the RAM write lands at this same edge,
      // which gives read-before-write for combined load/store.
      r_fault <= w_complete && w_fault && (w_do_read || w_do_write);
      if (w_complete) begin
        if (w_fault) begin
          r_read_data <= '0;
        end else if (w_do_read) begin
          r_read_data <= w_load_value;
        end
      end
    end
  end

  assign read_data_mem = r_read_data;
  assign mem_fault     = r_fault;
  assign mem_stall     = ((r_state == ST_IDLE) && w_req && HAS_WAIT) ||
                         ((r_state == ST_WAIT) && (r_cnt != '0));
  assign PCSrc_out     = Branch & Zero;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: two instances (0 and 2 wait states) driven
// with directed and random accesses; a byte-array model predicts each
// completion and per-instance monitors compare outputs from a scoreboard.
module tb_data_memory_unit;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [DW-1:0] rd;
    logic          flt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst         [2];
  logic [AW-1:0] address     [2];
  logic [DW-1:0] write_data  [2];
  logic          mem_read    [2];
  logic          mem_write   [2];
  logic          byte_acc    [2];
  logic          signed_load [2];
  logic          branch      [2];
  logic          zero        [2];
  logic [DW-1:0] rdm         [2];
  logic          pcsrc       [2];
  logic          stall       [2];
  logic          fault       [2];

  exp_t          sb_q [2][$];
  logic [7:0]    model_mem [2][DEPTH];
  logic [DW-1:0] model_rd  [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      data_memory_unit #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH_BYTES (DEPTH),
        .WAIT_STATES (gi*2)
      ) u_dut (
        .clk           (clk),
        .rst           (rst[gi]),
        .address       (address[gi]),
        .write_data    (write_data[gi]),
        .MemRead       (mem_read[gi]),
        .MemWrite      (mem_write[gi]),
        .ByteAccess    (byte_acc[gi]),
        .SignedLoad    (signed_load[gi]),
        .Branch        (branch[gi]),
        .Zero          (zero[gi]),
        .read_data_mem (rdm[gi]),
        .PCSrc_out     (pcsrc[gi]),
        .mem_stall     (stall[gi]),
        .mem_fault     (fault[gi])
      );

      // A request seen with mem_stall low completes at the next edge;
      // its results are checked at the following falling edge.
      logic pend = 1'b0;
      exp_t e;
      always @(negedge clk) begin
        if (pend) begin
          if (sb_q[gi].size() == 0) begin
            chk("sb_empty_at_completion", gi, 1, 0);
          end else begin
            e = sb_q[gi].pop_front();
            chk("read_data", gi, rdm[gi], e.rd);
            chk("fault", gi, fault[gi], e.flt);
          end
        end else if (!rst[gi]) begin
          chk("fault_idle", gi, fault[gi], 0);
        end
        pend <= (mem_read[gi] | mem_write[gi]) & ~stall[gi] & ~rst[gi];
      end
    end
  endgenerate

  // Called just after a rising edge; returns just after the completing edge.
  task automatic access(input int d, input int a, input logic [DW-1:0] wd,
                        input bit rd, input bit wr, input bit by, input bit sg,
                        input bit chk_stall);
    exp_t e;
    bit   flt;
    bit   done;
    int   stalls;
    logic [7:0] b0;
    flt = by ? (a >= DEPTH) : (a + DW/8 - 1 >= DEPTH);
    if (flt) begin
      model_rd[d] = '0;
    end else if (rd) begin
      b0 = model_mem[d][a];
      if (by) model_rd[d] = sg ? {{8{b0[7]}}, b0} : {8'h00, b0};
      else    model_rd[d] = {b0, model_mem[d][a+1]};
    end
    if (wr && !flt) begin
      if (by) model_mem[d][a] = wd[7:0];
      else begin
        model_mem[d][a]   = wd[15:8];
        model_mem[d][a+1] = wd[7:0];
      end
    end
    e.rd  = model_rd[d];
    e.flt = flt;
    sb_q[d].push_back(e);

    address[d]     = a[AW-1:0];
    write_data[d]  = wd;
    mem_read[d]    = rd;
    mem_write[d]   = wr;
    byte_acc[d]    = by;
    signed_load[d] = sg;
    stalls = 0;
    done   = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (stall[d]) stalls++;
      else done = 1;
    end
    if (!done) chk("stall_timeout", d, 0, 1);
    if (chk_stall) chk("stall_cycles", d, stalls, d*2);
    @(posedge clk);
    #1;
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int r;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; address[d] = '0; write_data[d] = '0;
      mem_read[d] = 1'b0; mem_write[d] = 1'b0; byte_acc[d] = 1'b0;
      signed_load[d] = 1'b0; branch[d] = 1'b0; zero[d] = 1'b0;
      model_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_read_data", d, rdm[d], 0);
      chk("reset_fault", d, fault[d], 0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("post_reset_stall", d, stall[d], 0);
      chk("post_reset_read_data", d, rdm[d], 0);
    end
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      // Fill the whole RAM so every later read has a known value.
      for (int a = 0; a < DEPTH; a += 2) access(d, a, DW'($urandom), 0, 1, 0, 0, 0);

      access(d, 'h010, 'hA55A, 0, 1, 0, 0, 1);
      access(d, 'h010, 0,      1, 0, 0, 0, 1);  // word load -> A55A
      access(d, 'h010, 0,      1, 0, 1, 0, 1);  // byte 0x010 -> 00A5
      access(d, 'h011, 0,      1, 0, 1, 0, 1);  // byte 0x011 -> 005A
      access(d, 'h020, 'h1280, 0, 1, 1, 0, 1);  // byte store 0x80
      access(d, 'h020, 0,      1, 0, 1, 1, 1);  // signed -> FF80
      access(d, 'h020, 0,      1, 0, 1, 0, 1);  // unsigned -> 0080
      access(d, 'h3FF, 'h1234, 0, 1, 0, 0, 1);  // word straddles end: fault
      access(d, 'h3FF, 0,      1, 0, 1, 0, 1);  // byte unchanged
      access(d, 'h3FE, 'h1234, 0, 1, 0, 0, 1);  // last full word: ok
      access(d, 'h3FE, 0,      1, 0, 0, 0, 1);
      access(d, 'h011, 'hC3C3, 0, 1, 0, 0, 1);  // misaligned word store
      access(d, 'h011, 0,      1, 0, 0, 0, 1);
      access(d, 'h050, 'h2222, 0, 1, 0, 0, 1);
      access(d, 'h050, 'h1111, 1, 1, 0, 0, 1);  // read-before-write -> 2222
      access(d, 'h050, 0,      1, 0, 0, 0, 1);  // -> 1111
      access(d, 'h400, 0,      1, 0, 1, 0, 1);  // byte just past end: fault
      access(d, 'h3FF, 0,      1, 0, 1, 1, 1);  // last byte: ok
      access(d, 'hFFFF, 'h5555, 1, 1, 0, 0, 1); // no wrap to address 0
      access(d, 'h000, 0,      1, 0, 0, 0, 1);

      for (int b = 0; b < 4; b++) begin
        @(posedge clk); #1;
        branch[d] = b[1]; zero[d] = b[0];
        #1;
        chk("pcsrc", d, pcsrc[d], b[1] & b[0]);
      end
      branch[d] = 1'b0; zero[d] = 1'b0;
      @(posedge clk); #1;

      repeat (150) begin
        r = $urandom_range(0, 2);
        access(d, $urandom_range(0, DEPTH + 3), DW'($urandom),
               (r != 1), (r != 0), 1'($urandom), 1'($urandom), 1);
      end
    end

    // Reset while a 2-wait-state store is pending: the store is abandoned.
    address[1] = 16'h040; write_data[1] = 16'hBEEF;
    mem_write[1] = 1'b1; byte_acc[1] = 1'b0;
    @(negedge clk);
    chk("abort_stall_start", 1, stall[1], 1);
    @(posedge clk); #1;
    rst[1] = 1'b1; mem_write[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    model_rd[1] = '0;
    @(negedge clk);
    chk("abort_stall", 1, stall[1], 0);
    chk("abort_read_data", 1, rdm[1], 0);
    chk("abort_fault", 1, fault[1], 0);
    @(posedge clk); #1;
    access(1, 'h040, 0, 1, 0, 0, 0, 1);  // original contents survive
    access(1, 'h040, 0, 1, 0, 1, 0, 1);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("sb_drained", d, sb_q[d].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
